dot4_mac_accumulator: RTL

- Sequential multiply-accumulate stage built around the team's 4x4 signed (two's complement) multiplier datapath.
- Accepts a stream of signed 4-bit operand pairs over a valid/ready handshake and forms each 8-bit signed product.
- Accumulates LEN products into one signed dot-product result and presents it downstream with its own valid/ready handshake.

---
 rtl/dot4_mac_accumulator_pkg.sv | 27 ++
 rtl/dot4_mac_accumulator_if.sv | 24 ++
 rtl/dot4_mac_accumulator_signed_mul4x4_core.sv | 27 ++
 rtl/dot4_mac_accumulator.sv | 104 ++++++++++
 4 files changed

// File: rtl/dot4_mac_accumulator_pkg.sv
// Shared types, widths and the saturating clamp used by the dot-product MAC.
package dot4_mac_accumulator_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_e;

    localparam int OPW   = 4;
    localparam int PRODW = 8;

    // Clamp a sign-extended (w+1)-bit sum into the signed range of w bits.
    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] s, input int w);
        logic signed [31:0] mx;
        logic signed [31:0] mn;
        mx = (32'sd1 <<< (w - 1)) - 32'sd1;
        mn = -(32'sd1 <<< (w - 1));
        if (s > mx)
            sat_clamp = mx;
        else if (s < mn)
            sat_clamp = mn;
        else
            sat_clamp = s;
    endfunction

endpackage

// File: rtl/dot4_mac_accumulator_if.sv
// Operand stream in, dot-product result out, plus the busy indicator.
interface dot4_mac_accumulator_if #(
    parameter int ACC_W = 10
);
    logic                                          in_valid;
    logic                                          in_ready;
    logic signed [dot4_mac_accumulator_pkg::OPW-1:0] in_x;
    logic signed [dot4_mac_accumulator_pkg::OPW-1:0] in_y;
    logic                                          out_valid;
    logic                                          out_ready;
    logic signed [ACC_W-1:0]                       out_sum;
    logic                                          out_sat;
    logic                                          busy;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_sum, out_sat, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_sum, out_sat, busy
    );
endinterface

// File: rtl/dot4_mac_accumulator_signed_mul4x4_core.sv
// Combinational 4x4 two's-complement multiplier built from shifted partial
// products; the MSB row of the multiplier carries negative weight, so it is
// subtracted instead of added.
module signed_mul4x4_core
    import dot4_mac_accumulator_pkg::*;
(
    input  logic signed [OPW-1:0]   a_i,
    input  logic signed [OPW-1:0]   b_i,
    output logic signed [PRODW-1:0] p_o
);
    logic [OPW-1:0][PRODW-1:0] pp;
    logic [PRODW-1:0]          sum;

    for (genvar i = 0; i < OPW; i++) begin : g_pp
        assign pp[i] = b_i[i] ? (PRODW'(a_i) << i) : '0;
    end

    // Sum the positive-weight rows, then remove the sign row.
    always_comb begin
        sum = '0;
        for (int i = 0; i < OPW - 1; i++)
            sum = sum + pp[i];
        sum = sum - pp[OPW-1];
    end

    assign p_o = sum;
endmodule

// File: rtl/dot4_mac_accumulator.sv
// Two-stage signed multiply-accumulate: registered product, then saturating
// accumulate; LEN terms form one result handed off over valid/ready.
module dot4_mac_accumulator
    import dot4_mac_accumulator_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    dot4_mac_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic signed [PRODW-1:0] prod_q;
    logic signed [PRODW-1:0] mul_p;
    logic                    prod_v_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    sat_q;
    logic signed [ACC_W:0]   sum_w;
    logic signed [31:0]      clamped;
    logic                    sat_hit;
    logic                    accept;
    logic                    handoff;

    signed_mul4x4_core u_mul (
        .a_i (bus.in_x),
        .b_i (bus.in_y),
        .p_o (mul_p)
    );

    assign accept  = bus.in_valid && (state_q == ACC);
    assign handoff = (state_q == OUT) && bus.out_ready;

    // One extra bit of headroom so the clamp sees the true sum.
    always_comb begin
        sum_w   = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_q);
        clamped = sat_clamp(32'(sum_w), ACC_W);
        sat_hit = (clamped != 32'(sum_w));
        acc_d   = ACC_W'(clamped);
    end

    // Next state and term counter.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = DRAIN;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DRAIN:   state_d = OUT;
            OUT:     if (bus.out_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Product stage and accumulator; handoff clears for the next vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            prod_v_q <= accept;
            if (accept)
                prod_q <= mul_p;
            if (handoff) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end else if (prod_v_q) begin
                acc_q <= acc_d;
                sat_q <= sat_q | sat_hit;
            end
        end
    end

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_sum   = (state_q == OUT) ? acc_q : '0;
    assign bus.out_sat   = (state_q == OUT) ? sat_q : 1'b0;
    assign bus.busy      = (count_q != '0) || (state_q != ACC);
endmodule
